// File: rtl/mdu_pkg.sv
// mdu_pkg: shared HILO operation codes and the HI/LO pair type used by the
// multiply/divide scheduler and its arithmetic unit. Code values match the
// decoder's macro.v so E-stage decode can be passed through unchanged.
package mdu_pkg;

  localparam logic [3:0] HILO_MULT  = 4'd0;
  localparam logic [3:0] HILO_MULTU = 4'd1;
  localparam logic [3:0] HILO_DIV   = 4'd2;
  localparam logic [3:0] HILO_DIVU  = 4'd3;
  localparam logic [3:0] HILO_MFHI  = 4'd4;
  localparam logic [3:0] HILO_MFLO  = 4'd5;
  localparam logic [3:0] HILO_MTHI  = 4'd6;
  localparam logic [3:0] HILO_MTLO  = 4'd7;
  localparam logic [3:0] HILO_NONE  = 4'b1111;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // Codes 0..3 are the multi-cycle mult/div operations.
  function automatic logic is_md_op(input logic [3:0] code);
    return (code[3:2] == 2'b00);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational result generator for mult/multu/div/divu.
// Ports:
//   op       in  4   HILO code (only 0..3 produce a result, others give 0)
//   rs, rt   in  32  operands A and B
//   res      out 64  {hi, lo} result
//   div_zero out 1   divisor is zero (result must not be committed)
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output hilo_t       res,
  output logic        div_zero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [32:0] dvd;
  logic signed [32:0] dvs;
  logic signed [31:0] quo;
  logic signed [31:0] rem;

  always_comb begin
    div_zero = (rt == 32'd0);
    prod_s   = 64'(signed'(rs)) * 64'(signed'(rt));
    prod_u   = 64'(rs) * 64'(rt);
    // 33-bit signed operands cover both divu and div; the extra bit also keeps
    // 0x80000000 / -1 from overflowing (it wraps to 0x80000000 in 32 bits).
    dvd = (op == HILO_DIV) ? {rs[31], rs} : {1'b0, rs};
    dvs = (op == HILO_DIV) ? {rt[31], rt} : {1'b0, rt};
    if (div_zero) begin
      dvs = 33'sd1;
    end
    quo = 32'(dvd / dvs);
    rem = 32'(dvd % dvs);
    res = '0;
    case (op)
      HILO_MULT:           res = prod_s;
      HILO_MULTU:          res = prod_u;
      HILO_DIV, HILO_DIVU: res = {rem, quo};
      default:             res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_scheduler.sv
// mdu_scheduler: sequences the shared multiply/divide unit and the HI/LO pair.
// An accepted mult/div loads a busy counter and captures its result in a
// pending register; the result is written to HI/LO as the counter expires.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   E_hilo_type  HILO code of the E-stage instruction (4'b1111 = none)
//   E_valid      E stage holds a real instruction
//   E_rs, E_rt   forwarded operands
//   flush        M-stage exception/eret: E instruction has no effect
//   D_md_use     D-stage instruction uses the md unit or HI/LO
//   start        md op accepted this cycle (combinational)
//   busy         operation in flight (registered)
//   stall_D      stall D while an op is being accepted or in flight
//   hilo_out     HI for mfhi, LO for mflo, else 0
module mdu_scheduler
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_hilo_type,
  input  logic        E_valid,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        flush,
  input  logic        D_md_use,
  output logic        start,
  output logic        busy,
  output logic        stall_D,
  output logic [31:0] hilo_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  hilo_t            pend_q, pend_d;
  logic             pend_we_q, pend_we_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  hilo_t            arith_res;
  logic             arith_dz;
  logic             act;

  mdu_arith u_arith (
    .op       (E_hilo_type),
    .rs       (E_rs),
    .rt       (E_rt),
    .res      (arith_res),
    .div_zero (arith_dz)
  );

  always_comb begin
    busy      = (cnt_q != '0);
    act       = E_valid & ~flush & ~busy;
    start     = act & is_md_op(E_hilo_type);
    stall_D   = D_md_use & (start | busy);
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_we_d = pend_we_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (start) begin
      cnt_d     = (E_hilo_type[1] == 1'b0) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      pend_d    = arith_res;
      // Divide by zero still occupies the unit but leaves HI/LO untouched.
      pend_we_d = ~(E_hilo_type[1] & arith_dz);
    end else if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && pend_we_q) begin
        hi_d = pend_q.hi;
        lo_d = pend_q.lo;
      end
    end else if (act && E_hilo_type == HILO_MTHI) begin
      hi_d = E_rs;
    end else if (act && E_hilo_type == HILO_MTLO) begin
      lo_d = E_rs;
    end

    case (E_hilo_type)
      HILO_MFHI: hilo_out = hi_q;
      HILO_MFLO: hilo_out = lo_q;
      default:   hilo_out = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_we_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_we_q <= pend_we_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_scheduler.sv
module tb_mdu_scheduler;

  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MFHI  = 4'd4;
  localparam logic [3:0] OP_MFLO  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd6;
  localparam logic [3:0] OP_MTLO  = 4'd7;
  localparam logic [3:0] OP_NONE  = 4'b1111;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_hilo_type;
  logic        E_valid;
  logic [31:0] E_rs;
  logic [31:0] E_rt;
  logic        flush;
  logic        D_md_use;
  logic        start;
  logic        busy;
  logic        stall_D;
  logic [31:0] hilo_out;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_scheduler #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
    .clk         (clk),
    .reset       (reset),
    .E_hilo_type (E_hilo_type),
    .E_valid     (E_valid),
    .E_rs        (E_rs),
    .E_rt        (E_rt),
    .flush       (flush),
    .D_md_use    (D_md_use),
    .start       (start),
    .busy        (busy),
    .stall_D     (stall_D),
    .hilo_out    (hilo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic v, input logic [31:0] rs,
                       input logic [31:0] rt, input logic fl, input logic du);
    E_hilo_type = op;
    E_valid     = v;
    E_rs        = rs;
    E_rt        = rt;
    flush       = fl;
    D_md_use    = du;
  endtask

  // Reference: results from plain 64-bit arithmetic on the architectural rules.
  task automatic model(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output logic [31:0] eh, output logic [31:0] el, output logic dz);
    longint      a, b, q, r;
    logic [63:0] p;
    p  = 64'd0;
    dz = 1'b0;
    case (op)
      OP_MULT:  p = longint'($signed(rs)) * longint'($signed(rt));
      OP_MULTU: p = {32'd0, rs} * {32'd0, rt};
      OP_DIV, OP_DIVU: begin
        if (rt == 32'd0) begin
          dz = 1'b1;
        end else begin
          if (op == OP_DIV) begin
            a = longint'($signed(rs));
            b = longint'($signed(rt));
          end else begin
            a = longint'({32'd0, rs});
            b = longint'({32'd0, rt});
          end
          q = a / b;
          r = a % b;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = 64'd0;
    endcase
    eh = p[63:32];
    el = p[31:0];
  endtask

  task automatic check_hilo(input string tag);
    drive(OP_MFHI, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk({tag, "_hi"}, hilo_out, m_hi);
    drive(OP_MFLO, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk({tag, "_lo"}, hilo_out, m_lo);
    drive(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Issue one md op, follow the busy window cycle by cycle, then update the model.
  task automatic run_md(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic du, input logic inject);
    logic [31:0] eh, el;
    logic        dz;
    int          n;
    model(op, rs, rt, eh, el, dz);
    n = (op == OP_MULT || op == OP_MULTU) ? MULT_C : DIV_C;
    drive(op, 1'b1, rs, rt, 1'b0, du);
    #1;
    chk("start_acc", {31'd0, start}, 32'd1);
    chk("stall_acc", {31'd0, stall_D}, {31'd0, du});
    tick();
    for (int i = 1; i <= n; i++) begin
      if (inject && i == 2)
        drive(OP_MTHI, 1'b1, $urandom, 32'd0, 1'b0, du);
      else
        drive(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0, du);
      #1;
      chk("busy_win", {31'd0, busy}, 32'd1);
      chk("stall_win", {31'd0, stall_D}, {31'd0, du});
      if (inject && i == 2) chk("start_ignored", {31'd0, start}, 32'd0);
      tick();
    end
    drive(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0, du);
    #1;
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("stall_end", {31'd0, stall_D}, 32'd0);
    if (!dz) begin
      m_hi = eh;
      m_lo = el;
    end
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] rs, input logic fl);
    drive(op, 1'b1, rs, 32'd0, fl, 1'b0);
    #1;
    chk("mt_start", {31'd0, start}, 32'd0);
    tick();
    drive(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("mt_busy", {31'd0, busy}, 32'd0);
    if (!fl) begin
      if (op == OP_MTHI) m_hi = rs;
      else m_lo = rs;
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic        fl, du;

    reset = 1'b1;
    drive(OP_MFHI, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1);
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd1 & 32'd0);
    chk("rst_stall", {31'd0, stall_D}, 32'd0);
    chk("rst_hi", hilo_out, 32'd0);
    tick();
    #3;
    reset = 1'b0;
    tick();
    check_hilo("post_rst");

    // mult -3 * 7, then mflo right after
    run_md(OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b1, 1'b0);
    chk("mult_hi_const", m_hi, 32'hFFFFFFFF);
    check_hilo("mult");
    drive(OP_MFLO, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("mflo_after_mult", hilo_out, 32'hFFFFFFEB);

    // divu 100/7 and div -7/2
    run_md(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    check_hilo("divu");
    run_md(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    check_hilo("div_neg");

    // divide by zero keeps HI/LO
    do_mt(OP_MTHI, 32'd5, 1'b0);
    do_mt(OP_MTLO, 32'd9, 1'b0);
    run_md(OP_DIV, 32'd77, 32'd0, 1'b1, 1'b0);
    check_hilo("div_zero");

    // mthi then mfhi
    do_mt(OP_MTHI, 32'd1234, 1'b0);
    check_hilo("mthi");

    // flushed mult has no effect and does not stall D
    drive(OP_MULT, 1'b1, 32'hFFFFFFFD, 32'd7, 1'b1, 1'b1);
    #1;
    chk("flush_start", {31'd0, start}, 32'd0);
    chk("flush_stall", {31'd0, stall_D}, 32'd0);
    tick();
    drive(OP_MFLO, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1);
    #1;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_stall2", {31'd0, stall_D}, 32'd0);
    check_hilo("flush");

    // multu interrupted by reset at t+2
    do_mt(OP_MTLO, 32'hA5A5A5A5, 1'b0);
    drive(OP_MULTU, 1'b1, 32'hFFFFFFFF, 32'd3, 1'b0, 1'b1);
    #1;
    chk("rmid_start", {31'd0, start}, 32'd1);
    chk("rmid_stall_t", {31'd0, stall_D}, 32'd1);
    tick();
    drive(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    #1;
    chk("rmid_stall_t1", {31'd0, stall_D}, 32'd1);
    tick();
    reset = 1'b1;
    drive(OP_MFLO, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1);
    #1;
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    chk("rmid_stall", {31'd0, stall_D}, 32'd0);
    chk("rmid_lo", hilo_out, 32'd0);
    #2;
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rmid_no_busy", {31'd0, busy}, 32'd0);
    end
    check_hilo("rmid_after");

    // randomized mix
    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(0, 7));
      rs = $urandom;
      rt = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 1) == 0) rs = 32'(-$signed(32'($urandom_range(0, 1000))));
      fl = ($urandom_range(0, 7) == 0);
      du = 1'($urandom_range(0, 1));
      case (op)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
          if (fl) begin
            drive(op, 1'b1, rs, rt, 1'b1, du);
            #1;
            chk("rnd_flush_start", {31'd0, start}, 32'd0);
            tick();
            drive(OP_NONE, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            #1;
            chk("rnd_flush_busy", {31'd0, busy}, 32'd0);
          end else begin
            run_md(op, rs, rt, du, ($urandom_range(0, 3) == 0));
          end
        end
        OP_MTHI, OP_MTLO: do_mt(op, rs, fl);
        default: ;
      endcase
      check_hilo("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
